// File: rtl/ms_d_ff_pkg.sv
// Purpose : shared constants and helpers for the master-slave D flip-flop.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents:
//   MS_D_FF_DEFAULT_WIDTH - default register width
//   MS_D_FF_MAX_WIDTH     - widest vector the reset helper can build
//   ms_d_ff_default_reset - default reset vector for a given width
package ms_d_ff_pkg;

  localparam int MS_D_FF_DEFAULT_WIDTH = 1;
  localparam int MS_D_FF_MAX_WIDTH     = 64;

  // Default reset pattern is all zeros. Bits at or above 'width' are
  // left at zero too, so callers can size-cast the result to any width
  // up to MS_D_FF_MAX_WIDTH.
  function automatic logic [MS_D_FF_MAX_WIDTH-1:0] ms_d_ff_default_reset(
    input int unsigned width
  );
    logic [MS_D_FF_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MS_D_FF_MAX_WIDTH; i++) begin
      if (i < int'(width)) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/ms_d_ff_latch.sv
// Purpose : WIDTH-bit level-sensitive D latch, one stage of the master-slave flop.
// Latency : combinational pass-through while en is high; holds while en is low.
// Backpressure: none; storage follows en only.
// Ports:
//   en - transparency enable (1 = transparent, 0 = hold)
//   d  - data in
//   q  - latched data out
module d_latch #(
  parameter int WIDTH = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_latch begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ms_d_ff.sv
// Purpose : WIDTH-bit edge-triggered D flip-flop built from two explicit latches.
// Latency : one rising clk edge from D (or reset) to Q.
// Backpressure: none; captures every rising edge.
// Ports:
//   clk   - clock, rising edge is the capture/update edge
//   reset - synchronous active-high reset, takes priority over D
//   D     - data in
//   Q     - registered data out (slave latch content)
//   Qn    - ~Q, present only when MS_D_FF_QN_EN is defined
// Build option: define MS_D_FF_QN_EN to add the complementary Qn output.
module ms_d_ff
  import ms_d_ff_pkg::*;
#(
  parameter int               WIDTH       = MS_D_FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(ms_d_ff_default_reset(WIDTH))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef MS_D_FF_QN_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  logic             w_clk_n;
  logic [WIDTH-1:0] w_master_d;
  logic [WIDTH-1:0] w_master_q;
  logic [WIDTH-1:0] w_slave_q;

  assign w_clk_n = ~clk;

  // Reset is folded into the master's input, so it is only seen through
  // the same open-while-low / pass-on-rise path as data. That makes it
  // synchronous: a reset pulse confined to the high phase never reaches Q.
  assign w_master_d = reset ? RESET_VALUE : D;

  // Master follows its input while clk is low and freezes at the rising edge.
  d_latch #(
    .WIDTH (WIDTH)
  ) u_master (
    .en (w_clk_n),
    .d  (w_master_d),
    .q  (w_master_q)
  );

  // Slave opens on the rising edge and shows the frozen master value; it
  // closes on the falling edge, so Q never moves while the master is open.
  d_latch #(
    .WIDTH (WIDTH)
  ) u_slave (
    .en (clk),
    .d  (w_master_q),
    .q  (w_slave_q)
  );

  assign Q = w_slave_q;

`ifdef MS_D_FF_QN_EN
  assign Qn = ~w_slave_q;
`endif

endmodule

// File: tb/tb_ms_d_ff.sv
// Purpose : directed self-checking bench for ms_d_ff (WIDTH=1 and WIDTH=8 instances).
// Latency : checks Q one time unit after each rising edge, or mid-phase.
// Backpressure: n/a.
// Build option: with MS_D_FF_QN_EN defined the Qn outputs are also checked.
module tb_ms_d_ff;

  logic       clk;
  logic       reset1;
  logic [0:0] d1;
  logic [0:0] q1;
  logic       reset8;
  logic [7:0] d8;
  logic [7:0] q8;
`ifdef MS_D_FF_QN_EN
  logic [0:0] qn1;
  logic [7:0] qn8;
`endif

  int checks;
  int errors;

  ms_d_ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .D     (d1),
    .Q     (q1)
`ifdef MS_D_FF_QN_EN
    ,
    .Qn    (qn1)
`endif
  );

  ms_d_ff #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset8),
    .D     (d8),
    .Q     (q8)
`ifdef MS_D_FF_QN_EN
    ,
    .Qn    (qn8)
`endif
  );

  // Period 10, low at t=0: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] exp);
    chk(tag, {7'd0, q1}, exp);
`ifdef MS_D_FF_QN_EN
    chk({tag, "_qn"}, {7'd0, qn1}, {7'd0, ~exp[0]});
`endif
  endtask

  task automatic chk8(input string tag, input logic [7:0] exp);
    chk(tag, q8, exp);
`ifdef MS_D_FF_QN_EN
    chk({tag, "_qn"}, qn8, ~exp);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held across the first edge; the wide instance sees D=3C under reset.
    reset1 = 1'b1;
    d1     = 1'b0;
    reset8 = 1'b1;
    d8     = 8'h3C;
    at(6);
    chk1("rst_q1", 8'h00);
    chk8("rst_prio_q8", 8'hA5);

    // Release reset during the low phase; the next edge captures D.
    at(10);
    reset1 = 1'b0;
    d1     = 1'b1;
    reset8 = 1'b0;
    at(16);
    chk1("cap_15", 8'h01);
    chk8("cap8_15", 8'h3C);

    // Glitch D while clk is high (15..20): Q must hold.
    at(17);
    d1 = 1'b0;
    d8 = 8'hFF;
    at(18);
    d1 = 1'b1;
    d8 = 8'h3C;
    at(19);
    chk1("glitch_hold", 8'h01);
    chk8("glitch8_hold", 8'h3C);

    // Falling edge at 20 with new D: Q unchanged until the edge at 25.
    at(20);
    d1 = 1'b0;
    d8 = 8'h5A;
    at(21);
    chk1("fall_20", 8'h01);
    chk8("fall8_20", 8'h3C);
    at(26);
    chk1("cap_25", 8'h00);
    chk8("cap8_25", 8'h5A);

    // Reset pulse confined to the high phase has no effect on the wide flop.
    at(27);
    reset8 = 1'b1;
    at(29);
    reset8 = 1'b0;
    at(36);
    chk1("cap_35", 8'h00);
    chk8("midrst8_35", 8'h5A);

    at(40);
    d1 = 1'b1;
    at(46);
    chk1("cap_45", 8'h01);
    at(56);
    chk1("cap_55", 8'h01);
    at(66);
    chk1("cap_65", 8'h01);

    // D drops exactly at the falling edge at 70: Q stays 1 through the low phase.
    at(70);
    d1 = 1'b0;
    at(71);
    chk1("fall_70", 8'h01);
    at(76);
    chk1("cap_75", 8'h00);
    at(86);
    chk1("cap_85", 8'h00);
    at(106);
    chk1("cap_105", 8'h00);

    // Mid-cycle reset pulse while clk is high, Q=1, D=1: Q stays 1.
    at(110);
    d1 = 1'b1;
    at(116);
    chk1("cap_115", 8'h01);
    reset1 = 1'b1;
    at(118);
    chk1("midrst_hold", 8'h01);
    at(119);
    reset1 = 1'b0;
    at(126);
    chk1("midrst_125", 8'h01);

    // Reset asserted in the low phase and held across the edge at 135.
    at(130);
    reset1 = 1'b1;
    at(133);
    chk1("rst_pre_edge", 8'h01);
    at(136);
    chk1("rst_135", 8'h00);

    // Reset released just before the edge at 145: that edge captures D.
    at(144);
    reset1 = 1'b0;
    at(146);
    chk1("rst_rel_145", 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
